// File: rtl/nn_pkg.sv
// Shared types and helpers for the layer neuron processing elements.
package nn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_DRAIN,
        ST_FIN,
        ST_OUT
    } pe_state_t;

    localparam logic [1:0] ACT_IDENTITY = 2'd0;
    localparam logic [1:0] ACT_RELU     = 2'd1;
    localparam logic [1:0] ACT_LEAKY    = 2'd2;

    // Signed a+b clamped to the signed range of a w-bit value.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [64:0] s;
        logic signed [64:0] mx;
        logic signed [64:0] mn;
        s  = {a[63], a} + {b[63], b};
        mx = (65'sd1 <<< (w - 1)) - 65'sd1;
        mn = -(65'sd1 <<< (w - 1));
        if (s > mx)
            return mx[63:0];
        else if (s < mn)
            return mn[63:0];
        else
            return s[63:0];
    endfunction

endpackage

// File: rtl/pe_weight_mem.sv
// Weight store: one word per beat, lane-masked write, registered read.
module pe_weight_mem #(
    parameter int DEPTH = 2,
    parameter int LANES = 2,
    parameter int DW    = 16,
    parameter int AW    = 1
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [LANES-1:0]    wmask,
    input  logic [LANES*DW-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [LANES*DW-1:0] rdata
);

    logic [LANES*DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (we && wmask[k])
                mem[waddr][k*DW +: DW] <= wdata[k*DW +: DW];
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/neuron_pe.sv
// Multi-lane neuron: MAC over LANES inputs per beat, bias, activation,
// valid/ready on both sides and config-bus loaded weights and bias.
module neuron_pe
    import nn_pkg::*;
#(
    parameter int LAYER_NO   = 1,
    parameter int NEURON_NO  = 0,
    parameter int NUM_WEIGHT = 784,
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        weight_valid,
    input  logic                        bias_valid,
    input  logic [31:0]                 weight_value,
    input  logic [31:0]                 bias_value,
    input  logic [31:0]                 config_layer_num,
    input  logic [31:0]                 config_neuron_num,
    input  logic [1:0]                  act_sel,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int DW    = DATA_WIDTH;
    localparam int PW    = 2 * DW;
    localparam int DEPTH = NUM_WEIGHT / LANES;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW    = $clog2(DEPTH + 1);
    localparam int WPW   = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
    localparam int SW    = PW + $clog2(LANES);

    pe_state_t              state;
    logic [1:0]             drain_cnt;
    logic [BW-1:0]          beat_cnt;
    logic [WPW-1:0]         wptr;
    logic signed [DW-1:0]   bias_q;
    logic signed [PW-1:0]   acc;
    logic                   v1;
    logic                   v2;
    logic [LANES*DW-1:0]    x_q;
    logic [LANES*DW-1:0]    w_rd;
    logic signed [PW-1:0]   prod_q [LANES];
    logic signed [SW-1:0]   tree;

    logic                   hs;
    logic                   cfg_hit;
    logic                   w_we;
    logic                   b_we;
    logic [AW-1:0]          w_addr;
    logic [LANES-1:0]       w_mask;
    logic signed [63:0]     acc_sum;
    logic signed [63:0]     biased;
    logic signed [63:0]     shifted;
    logic signed [63:0]     clipped;
    logic signed [DW-1:0]   y;
    logic signed [DW-1:0]   act_y;
    logic                   unused_bits;

    assign in_ready  = !rst && (state == ST_IDLE || state == ST_ACC);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_OUT);
    assign hs        = in_valid && in_ready;

    assign cfg_hit = (config_layer_num == 32'(LAYER_NO))
                  && (config_neuron_num == 32'(NEURON_NO))
                  && !busy;
    assign w_we    = weight_valid && cfg_hit;
    assign b_we    = bias_valid && cfg_hit;
    assign w_addr  = AW'(32'(wptr) / 32'(LANES));
    assign w_mask  = LANES'(1) << (32'(wptr) % 32'(LANES));

    pe_weight_mem #(
        .DEPTH (DEPTH),
        .LANES (LANES),
        .DW    (DW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_addr),
        .wmask (w_mask),
        .wdata ({LANES{weight_value[DW-1:0]}}),
        .raddr (AW'(beat_cnt)),
        .rdata (w_rd)
    );

    always_ff @(posedge clk) begin
        if (hs)
            x_q <= in_data;
        for (int k = 0; k < LANES; k++)
            prod_q[k] <= $signed(x_q[k*DW +: DW])
                       * $signed(w_rd[k*DW +: DW]);
    end

    always_comb begin
        tree = '0;
        for (int k = 0; k < LANES; k++)
            tree = tree + SW'(prod_q[k]);
    end

    always_comb begin
        acc_sum = sat_add(64'(acc), 64'(tree), PW);
        biased  = sat_add(64'(acc), 64'(bias_q) <<< FRAC_BITS, PW);
        shifted = biased >>> FRAC_BITS;
        clipped = sat_add(shifted, 64'sd0, DW);
        y       = clipped[DW-1:0];
        case (act_sel)
            ACT_RELU:  act_y = y[DW-1] ? '0 : y;
            ACT_LEAKY: act_y = y[DW-1] ? (y >>> 3) : y;
            default:   act_y = y;
        endcase
    end

    assign unused_bits = ^{weight_value[31:DW], bias_value[31:DW],
                           biased[FRAC_BITS-1:0], clipped[63:DW],
                           acc_sum[63:PW]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            beat_cnt  <= '0;
            wptr      <= '0;
            bias_q    <= '0;
            acc       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_data  <= '0;
        end else begin
            v1 <= hs;
            v2 <= v1;
            if (hs)
                beat_cnt <= beat_cnt + 1'b1;
            if (v2)
                acc <= acc_sum[PW-1:0];
            if (w_we)
                wptr <= (wptr == WPW'(NUM_WEIGHT - 1)) ? '0 : wptr + 1'b1;
            if (b_we)
                bias_q <= bias_value[DW-1:0];
            case (state)
                ST_IDLE, ST_ACC: begin
                    if (hs)
                        state <= (beat_cnt == BW'(DEPTH - 1))
                               ? ST_DRAIN : ST_ACC;
                end
                // Third drain cycle fixes the result at five cycles after the last beat.
                ST_DRAIN: begin
                    if (drain_cnt == 2'd2) begin
                        drain_cnt <= '0;
                        state     <= ST_FIN;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                ST_FIN: begin
                    out_data <= act_y;
                    state    <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state    <= ST_IDLE;
                        acc      <= '0;
                        beat_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_pe.sv
// Directed bench for neuron_pe with a result scoreboard (2 lanes, 4 weights).
module tb_neuron_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        weight_valid;
    logic        bias_valid;
    logic [31:0] weight_value;
    logic [31:0] bias_value;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic [1:0]  act_sel;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int          cyc = 0;
    int          hs_cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_q [$];
    logic [15:0] last_exp;

    neuron_pe #(
        .LAYER_NO   (1),
        .NEURON_NO  (0),
        .NUM_WEIGHT (4),
        .LANES      (2),
        .DATA_WIDTH (16),
        .FRAC_BITS  (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .weight_valid      (weight_valid),
        .bias_valid        (bias_valid),
        .weight_value      (weight_value),
        .bias_value        (bias_value),
        .config_layer_num  (config_layer_num),
        .config_neuron_num (config_neuron_num),
        .act_sel           (act_sel),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .busy              (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wr_weight(input logic [15:0] v, input logic [31:0] lay,
                             input logic [31:0] neu);
        config_layer_num  = lay;
        config_neuron_num = neu;
        weight_value      = {16'hdead, v};
        weight_valid      = 1'b1;
        @(negedge clk);
        weight_valid      = 1'b0;
        config_layer_num  = 32'd1;
        config_neuron_num = 32'd0;
    endtask

    task automatic wr_bias(input logic [15:0] v);
        bias_value = {16'hbeef, v};
        bias_valid = 1'b1;
        @(negedge clk);
        bias_valid = 1'b0;
    endtask

    task automatic load4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        wr_weight(a, 32'd1, 32'd0);
        wr_weight(b, 32'd1, 32'd0);
        wr_weight(c, 32'd1, 32'd0);
        wr_weight(d, 32'd1, 32'd0);
    endtask

    task automatic send_beat(input logic [15:0] l0, input logic [15:0] l1);
        int n = 0;
        in_data  = {l1, l0};
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("beat_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        hs_cyc   = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [15:0] a0, input logic [15:0] a1,
                            input logic [15:0] b0, input logic [15:0] b1,
                            input logic [15:0] exp);
        exp_q.push_back(exp);
        send_beat(a0, a1);
        send_beat(b0, b1);
    endtask

    task automatic get_result(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_cycle"}, 32'(cyc - hs_cyc + 1), 32'd5);
        check({tag, "_sb"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            check(tag, {16'd0, out_data}, {16'd0, last_exp});
        end
    endtask

    task automatic after_take(input string tag);
        @(negedge clk);
        check({tag, "_ovld"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        in_data           = '0;
        in_valid          = 1'b0;
        weight_valid      = 1'b0;
        bias_valid        = 1'b0;
        weight_value      = '0;
        bias_value        = '0;
        config_layer_num  = 32'd1;
        config_neuron_num = 32'd0;
        act_sel           = 2'd0;
        out_ready         = 1'b1;

        @(negedge clk);
        check("rst_rdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rdy", {31'd0, in_ready}, 32'd1);
        check("post_ovld", {31'd0, out_valid}, 32'd0);
        check("post_data", {16'd0, out_data}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);

        // 1.0, 2.0, -1.0, 0.5 with bias 0.25
        load4(16'h0100, 16'h0200, 16'hff00, 16'h0080);
        wr_bias(16'h0040);

        send_vec(16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0340);
        wr_weight(16'h7fff, 32'd1, 32'd0);
        wr_bias(16'h7fff);
        get_result("basic");
        after_take("basic");

        wr_weight(16'h7fff, 32'd1, 32'd5);
        wr_weight(16'h7fff, 32'd3, 32'd0);
        send_vec(16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0340);
        get_result("idmiss");
        after_take("idmiss");

        wr_bias(16'hf840);
        act_sel = 2'd0;
        send_vec(16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'hfb40);
        get_result("act_id");
        after_take("act_id");
        act_sel = 2'd1;
        send_vec(16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0000);
        get_result("act_relu");
        after_take("act_relu");
        act_sel = 2'd2;
        send_vec(16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'hff68);
        get_result("act_leaky");
        after_take("act_leaky");
        act_sel = 2'd3;
        send_vec(16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'hfb40);
        get_result("act_3");
        after_take("act_3");

        act_sel   = 2'd0;
        out_ready = 1'b0;
        send_vec(16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'hfb40);
        get_result("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_ovld", {31'd0, out_valid}, 32'd1);
            check("bp_data", {16'd0, out_data}, {16'd0, last_exp});
            check("bp_rdy", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        after_take("bp");

        load4(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
        send_vec(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
        get_result("sat_pos");
        after_take("sat_pos");
        send_vec(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        get_result("sat_neg");
        after_take("sat_neg");

        load4(16'h0100, 16'h0200, 16'hff00, 16'h0080);
        wr_bias(16'h0040);
        send_beat(16'h0100, 16'h0100);
        rst = 1'b1;
        @(negedge clk);
        check("mid_ovld", {31'd0, out_valid}, 32'd0);
        check("mid_rdy", {31'd0, in_ready}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_data", {16'd0, out_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel", {31'd0, in_ready}, 32'd1);
        // bias is cleared by reset, weights survive
        send_vec(16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0300);
        get_result("resend");
        after_take("resend");

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
